// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch control block.
// The state encoding is visible on the sw_ctrl state port, so it must stay fixed.
package sw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

    localparam int DIV_DEFAULT = 50000000;

endpackage

// File: rtl/sw_prescaler.sv
// Divides clk down to a one-cycle seconds tick.
// The count holds while en is low, so a pause keeps the fractional second.
module sw_prescaler
    import sw_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // Tick is combinational so it lands in the same cycle the count sits at DIV-1.
    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/sw_ctrl.sv
// Stopwatch control FSM: start/stop, lap freeze, clear and display mux.
// Define SW_CTRL_OVF_STOP_EN to auto-pause (with an ovf pulse) instead of wrapping past 59 s.
module sw_ctrl
    import sw_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    input  logic [3:0] sec_low,
    input  logic [3:0] sec_high,
    output logic       sec_tick,
    output logic       cnt_clr,
    output logic [3:0] disp_low,
    output logic [3:0] disp_high,
    output logic [1:0] state,
    output logic       ovf
);

    sw_state_t  st;
    logic       freeze;
    logic [3:0] lap_low;
    logic [3:0] lap_high;
    logic       counting;
    logic       idle;
    logic       tick_raw;
    logic       ovf_hit;

    assign counting = (st == ST_RUN) || (st == ST_LAP);
    assign idle     = (st == ST_IDLE);

    sw_prescaler #(.DIV(DIV)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (counting),
        .clr     (idle),
        .tick    (tick_raw)
    );

`ifdef SW_CTRL_OVF_STOP_EN
    assign ovf_hit = tick_raw && (sec_high == 4'd5) && (sec_low == 4'd9);
`else
    assign ovf_hit = 1'b0;
`endif

    assign sec_tick  = tick_raw && !ovf_hit;
    assign ovf       = ovf_hit;
    assign cnt_clr   = (st == ST_PAUSE) && btn_clr;
    assign disp_low  = freeze ? lap_low  : sec_low;
    assign disp_high = freeze ? lap_high : sec_high;
    assign state     = st;

    // freeze doubles as the memory of whether PAUSE was entered from LAP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= ST_IDLE;
            freeze   <= 1'b0;
            lap_low  <= 4'd0;
            lap_high <= 4'd0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (btn_ss) st <= ST_RUN;
                end
                ST_RUN: begin
                    if (ovf_hit || btn_ss) begin
                        st <= ST_PAUSE;
                    end else if (btn_lap) begin
                        st       <= ST_LAP;
                        freeze   <= 1'b1;
                        lap_low  <= sec_low;
                        lap_high <= sec_high;
                    end
                end
                ST_LAP: begin
                    if (ovf_hit || btn_ss) begin
                        st <= ST_PAUSE;
                    end else if (btn_lap) begin
                        st     <= ST_RUN;
                        freeze <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (btn_clr) begin
                        st     <= ST_IDLE;
                        freeze <= 1'b0;
                    end else if (btn_ss) begin
                        st <= freeze ? ST_LAP : ST_RUN;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_ctrl.sv
// Self-checking bench for sw_ctrl with DIV=4: directed scenarios, then random buttons.
// Expectations follow SW_CTRL_OVF_STOP_EN the same way the design build does.
module tb_sw_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_ss, btn_lap, btn_clr;
    logic [3:0] sec_low, sec_high;
    logic       sec_tick, cnt_clr, ovf;
    logic [3:0] disp_low, disp_high;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    // Reference model: stopwatch mode, counting cycles into the current second, live seconds.
    int m_mode;
    int m_phase;
    int m_lap;
    bit m_frozen;
    int secs;

    int cyc;
    int last_tick_cyc;
    int ovf_seen;
    int tick_q[$];

    sw_ctrl #(.DIV(DIV)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_ss    (btn_ss),
        .btn_lap   (btn_lap),
        .btn_clr   (btn_clr),
        .sec_low   (sec_low),
        .sec_high  (sec_high),
        .sec_tick  (sec_tick),
        .cnt_clr   (cnt_clr),
        .disp_low  (disp_low),
        .disp_high (disp_high),
        .state     (state),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_phase = 0;
        m_lap = 0;
        m_frozen = 0;
    endtask

    // One clock cycle: apply buttons, check outputs at negedge, advance the model.
    task automatic step(input bit ss, input bit lap, input bit clr);
        bit running, wrap, at59, e_tick, e_ovf, e_clr;
        int dsp;
        btn_ss   = ss;
        btn_lap  = lap;
        btn_clr  = clr;
        sec_low  = 4'(secs % 10);
        sec_high = 4'(secs / 10);
        @(negedge clk);
        running = (m_mode == 1) || (m_mode == 3);
        wrap    = running && (m_phase == DIV - 1);
        at59    = (secs == 59);
`ifdef SW_CTRL_OVF_STOP_EN
        e_ovf  = wrap && at59;
        e_tick = wrap && !at59;
`else
        e_ovf  = 1'b0;
        e_tick = wrap;
`endif
        e_clr = (m_mode == 2) && clr;
        dsp   = m_frozen ? m_lap : secs;
        chk("state", int'(state), m_mode);
        chk("sec_tick", int'(sec_tick), int'(e_tick));
        chk("cnt_clr", int'(cnt_clr), int'(e_clr));
        chk("ovf", int'(ovf), int'(e_ovf));
        chk("disp_low", int'(disp_low), dsp % 10);
        chk("disp_high", int'(disp_high), dsp / 10);
        if (sec_tick) begin
            last_tick_cyc = cyc;
            tick_q.push_back(cyc);
        end
        if (ovf) ovf_seen++;

        if (running) m_phase = (m_phase + 1) % DIV;
        case (m_mode)
            0: if (ss) m_mode = 1;
            1: begin
                if (e_ovf || ss) m_mode = 2;
                else if (lap) begin
                    m_mode = 3;
                    m_frozen = 1;
                    m_lap = secs;
                end
            end
            3: begin
                if (e_ovf || ss) m_mode = 2;
                else if (lap) begin
                    m_mode = 1;
                    m_frozen = 0;
                end
            end
            default: begin
                if (clr) begin
                    m_mode = 0;
                    m_frozen = 0;
                end else if (ss) m_mode = m_frozen ? 3 : 1;
            end
        endcase
        if (m_mode == 0) m_phase = 0;
        if (e_tick) secs = (secs + 1) % 60;
        if (e_clr) secs = 0;
        cyc++;
        @(posedge clk);
        #1;
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        sec_low  = 4'(secs % 10);
        sec_high = 4'(secs / 10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_sec_tick", int'(sec_tick), 0);
        chk("rst_cnt_clr", int'(cnt_clr), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_disp_low", int'(disp_low), secs % 10);
        chk("rst_disp_high", int'(disp_high), secs / 10);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r;
        reset_n = 1'b0;
        btn_ss = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
        secs = 0;
        sec_low = 4'd0;
        sec_high = 4'd0;
        cyc = 0;
        last_tick_cyc = -1;
        ovf_seen = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Start at cycle 0, ticks expected at cycles 4, 8, 12.
        cyc = 0;
        tick_q.delete();
        step(1, 0, 0);
        repeat (12) step(0, 0, 0);
        chk("first_ticks_count", tick_q.size(), 3);
        if (tick_q.size() >= 3) begin
            chk("tick0_cycle", tick_q[0], 4);
            chk("tick1_cycle", tick_q[1], 8);
            chk("tick2_cycle", tick_q[2], 12);
        end

        // Pause 2 cycles after a tick, hold, resume: tick 2 cycles after resume.
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        r = cyc;
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("resume_tick_cycle", last_tick_cyc, r + 2);

        // Lap capture of 23 s, held while live seconds move on, then released.
        secs = 23;
        step(0, 1, 0);
        repeat (9) step(0, 0, 0);
        chk("lap_hold_low", int'(disp_low), 3);
        chk("lap_hold_high", int'(disp_high), 2);
        step(0, 1, 0);
        step(0, 0, 0);
        chk("live_low", int'(disp_low), int'(sec_low));
        chk("live_high", int'(disp_high), int'(sec_high));

        // Clear and start together while paused: clear wins.
        step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        step(1, 0, 1);
        step(0, 0, 0);
        chk("clr_state", int'(state), 0);

        // Tick while showing 59 s.
        step(1, 0, 0);
        secs = 59;
        ovf_seen = 0;
        repeat (DIV) step(0, 0, 0);
`ifdef SW_CTRL_OVF_STOP_EN
        chk("ovf_count", ovf_seen, 1);
        chk("ovf_state", int'(state), 2);
        step(1, 0, 0);
`else
        chk("ovf_count", ovf_seen, 0);
        chk("ovf_state", int'(state), 1);
`endif

        // Reset while running, mid-prescale.
        repeat (2) step(0, 0, 0);
        do_reset();
        repeat (DIV + 2) step(0, 0, 0);

        // Random buttons, occasional near-overflow seconds and resets.
        repeat (600) begin
            if ($urandom_range(0, 19) == 0) secs = $urandom_range(55, 59);
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
